// File: rtl/dom_argmax_collector.sv
// Captures CNN output-write frames into a two-bank ping-pong buffer and reports
// the argmax of each sealed frame on a valid/ready result port.
module dom_argmax_collector #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_CLASSES    = 8,
  parameter int SIGNED_COMPARE = 0,
  localparam int AW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  dom_ready,
  input  logic [AW-1:0]         dom_address,
  input  logic [DATA_WIDTH-1:0] dom_data,
  input  logic                  flush,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [AW-1:0]         res_class,
  output logic [DATA_WIDTH-1:0] res_value,
  output logic                  overrun,
  output logic                  dup_write,
  output logic [1:0]            dbg_state
);

  // Result port: res_valid stays high and res_class/res_value stay stable until
  // the cycle res_valid && res_ready; that edge transfers the result and frees its bank.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_HOLD = 2'd2} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CLASSES - 1);

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  mem_q [2][NUM_CLASSES];
  logic [NUM_CLASSES-1:0] mask_q [2];
  logic [NUM_CLASSES-1:0] mask_d [2];
  logic [1:0]             busy_q, busy_d;
  logic                   wb_q, wb_d;
  logic                   cur_q, cur_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  best_val_q, best_val_d;
  logic [AW-1:0]          best_idx_q, best_idx_d;
  logic                   res_valid_q, res_valid_d;
  logic [AW-1:0]          res_class_q, res_class_d;
  logic [DATA_WIDTH-1:0]  res_value_q, res_value_d;
  logic                   overrun_q, overrun_d;
  logic                   dup_q, dup_d;

  logic                   pending;
  logic                   write_ok;
  logic                   handshake;
  logic                   other_free;
  logic                   seal;
  logic [NUM_CLASSES-1:0] mask_eff;
  logic [NUM_CLASSES-1:0] mask_new;
  logic [DATA_WIDTH-1:0]  scan_val;
  logic [DATA_WIDTH-1:0]  cand_val;
  logic [AW-1:0]          cand_idx;

  function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (SIGNED_COMPARE != 0) return $signed(a) > $signed(b);
    else                     return a > b;
  endfunction

  // A busy write bank means it sealed while the other bank was still occupied.
  assign pending    = busy_q[wb_q];
  assign write_ok   = dom_ready && !pending;
  assign handshake  = (state_q == S_HOLD) && res_ready;
  assign other_free = !busy_q[~wb_q] || (handshake && (cur_q == ~wb_q));
  assign mask_eff   = (go && !pending) ? '0 : mask_q[wb_q];
  assign mask_new   = mask_eff | (write_ok ? (NUM_CLASSES'(1) << dom_address) : '0);
  assign seal       = !pending && ((&mask_new) || (flush && (|mask_new)));
  // Entries never written in a flushed frame score as zero.
  assign scan_val   = mask_q[cur_q][idx_q] ? mem_q[cur_q][idx_q] : '0;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_d       = cur_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    res_value_d = res_value_q;
    wb_d        = wb_q;
    busy_d      = busy_q;
    mask_d[0]   = mask_q[0];
    mask_d[1]   = mask_q[1];
    cand_val    = best_val_q;
    cand_idx    = best_idx_q;
    overrun_d   = (go ? 1'b0 : overrun_q) | (dom_ready && pending);
    dup_d       = (go ? 1'b0 : dup_q) | (write_ok && mask_eff[dom_address]);

    if (!pending) mask_d[wb_q] = mask_new;
    if (seal) busy_d[wb_q] = 1'b1;
    if ((seal || pending) && other_free) wb_d = ~wb_q;

    case (state_q)
      S_IDLE: begin
        if (|busy_q) begin
          // Prefer the bank not scanned last: it is the older of two sealed banks.
          cur_d   = busy_q[~cur_q] ? ~cur_q : cur_q;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if ((idx_q == '0) || gt(scan_val, best_val_q)) begin
          cand_val = scan_val;
          cand_idx = idx_q;
        end
        best_val_d = cand_val;
        best_idx_d = cand_idx;
        if (idx_q == LAST_IDX) begin
          state_d     = S_HOLD;
          res_valid_d = 1'b1;
          res_class_d = cand_idx;
          res_value_d = cand_val;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          state_d        = S_IDLE;
          res_valid_d    = 1'b0;
          mask_d[cur_q]  = '0;
          busy_d[cur_q]  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cur_q       <= 1'b1;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_value_q <= '0;
      wb_q        <= 1'b0;
      busy_q      <= '0;
      mask_q[0]   <= '0;
      mask_q[1]   <= '0;
      overrun_q   <= 1'b0;
      dup_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_q       <= cur_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_value_q <= res_value_d;
      wb_q        <= wb_d;
      busy_q      <= busy_d;
      mask_q[0]   <= mask_d[0];
      mask_q[1]   <= mask_d[1];
      overrun_q   <= overrun_d;
      dup_q       <= dup_d;
    end
  end

  // Score storage needs no reset: the valid masks gate every read.
  always_ff @(posedge clock) begin
    if (write_ok) mem_q[wb_q][dom_address] <= dom_data;
  end

  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_value = res_value_q;
  assign overrun   = overrun_q;
  assign dup_write = dup_q;
  assign dbg_state = state_q;

endmodule
